// File: rtl/lcd_init_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_init_controller_pkg
// Description : State encodings, init/config tables and the long-command
//               predicate shared by the LCD init controller.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_init_controller_pkg;

    localparam int c_cnt_w = 20;

    typedef logic [c_cnt_w-1:0] cnt_t;
    typedef logic [3:0]         state_t;

    localparam state_t c_st_pwr_wait  = 4'd0;
    localparam state_t c_st_nib       = 4'd1;
    localparam state_t c_st_nib_wait  = 4'd2;
    localparam state_t c_st_cfg_issue = 4'd3;
    localparam state_t c_st_cfg_wait  = 4'd4;
    localparam state_t c_st_idle      = 4'd5;
    localparam state_t c_st_issue     = 4'd6;
    localparam state_t c_st_busy      = 4'd7;

    // Power-on wake-up nibbles: 3, 3, 3 then 2 to switch into 4-bit mode.
    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        logic [3:0] nib;
        nib = 4'h3;
        if (idx == 2'd3) begin
            nib = 4'h2;
        end
        return nib;
    endfunction

    // Function set, entry mode, display on, clear display.
    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        logic [7:0] val;
        case (idx)
            2'd0:    val = 8'h28;
            2'd1:    val = 8'h06;
            2'd2:    val = 8'h0C;
            default: val = 8'h01;
        endcase
        return val;
    endfunction

    // Clear display and return home need the long execution time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (!rs) && (data[7:2] == 6'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_init_controller.sv
`default_nettype none
// ============================================================================
// Module      : lcd_init_controller
// Description : Power-on init sequencer for the Spartan-3E character LCD;
//               afterwards forwards host commands/characters to command_sender.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_init_controller
    import lcd_init_controller_pkg::*;
#(
    parameter int T_POWERON = 750000,
    parameter int T_INIT1   = 205000,
    parameter int T_INIT2   = 5000,
    parameter int T_INIT3   = 2000,
    parameter int NIB_PULSE = 12,
    parameter int T_CMD     = 3110,
    parameter int T_CLEAR   = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       init_done,
    output logic       cs_start,
    output logic       cs_rs,
    output logic       cs_rw,
    output logic [7:0] cs_data,
    input  logic       cs_lcd_rs,
    input  logic [3:0] cs_sf_d,
    input  logic       cs_lcd_rw,
    input  logic       cs_lcd_e,
    output logic       lcd_rs,
    output logic [3:0] sf_d,
    output logic       lcd_rw,
    output logic       lcd_e
);

    // Each limit is the counter value sampled on the exit edge. Config waits
    // include the one-cycle issue state; busy waits also include the IDLE
    // cycle, so start-to-start spacing equals T_CMD / T_CLEAR exactly.
    localparam cnt_t c_pwr_lim      = cnt_t'(T_POWERON - 1);
    localparam cnt_t c_e_on         = cnt_t'(1);
    localparam cnt_t c_e_off        = cnt_t'(NIB_PULSE + 1);
    localparam cnt_t c_init1_lim    = cnt_t'(T_INIT1 - 1);
    localparam cnt_t c_init2_lim    = cnt_t'(T_INIT2 - 1);
    localparam cnt_t c_init3_lim    = cnt_t'(T_INIT3 - 1);
    localparam cnt_t c_cfg_cmd_lim  = cnt_t'(T_CMD - 2);
    localparam cnt_t c_cfg_clr_lim  = cnt_t'(T_CLEAR - 2);
    localparam cnt_t c_busy_cmd_lim = cnt_t'(T_CMD - 3);
    localparam cnt_t c_busy_clr_lim = cnt_t'(T_CLEAR - 3);

    state_t     r_state;
    cnt_t       r_cnt;
    logic [1:0] r_idx;
    logic       r_mux_cs;
    logic [3:0] r_ctl_sf_d;
    logic       r_ctl_e;
    logic       r_req_ready;
    logic       r_init_done;
    logic       r_cs_start;
    logic       r_cs_rs;
    logic [7:0] r_cs_data;

    cnt_t       w_nib_wait_lim;
    cnt_t       w_cfg_lim;
    cnt_t       w_busy_lim;
    logic       w_long;

    assign w_long     = is_long_cmd(r_cs_rs, r_cs_data);
    assign w_cfg_lim  = w_long ? c_cfg_clr_lim  : c_cfg_cmd_lim;
    assign w_busy_lim = w_long ? c_busy_clr_lim : c_busy_cmd_lim;

    always_comb begin
        w_nib_wait_lim = c_init3_lim;
        case (r_idx)
            2'd0:    w_nib_wait_lim = c_init1_lim;
            2'd1:    w_nib_wait_lim = c_init2_lim;
            default: w_nib_wait_lim = c_init3_lim;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_pwr_wait;
            r_cnt       <= '0;
            r_idx       <= 2'd0;
            r_mux_cs    <= 1'b0;
            r_ctl_sf_d  <= 4'h0;
            r_ctl_e     <= 1'b0;
            r_req_ready <= 1'b0;
            r_init_done <= 1'b0;
            r_cs_start  <= 1'b0;
            r_cs_rs     <= 1'b0;
            r_cs_data   <= 8'h00;
        end else begin
            r_cs_start <= 1'b0;
            r_cnt      <= r_cnt + cnt_t'(1);

            case (r_state)
                c_st_pwr_wait: begin
                    if (r_cnt == c_pwr_lim) begin
                        r_state    <= c_st_nib;
                        r_cnt      <= '0;
                        r_idx      <= 2'd0;
                        r_ctl_sf_d <= init_nibble(2'd0);
                    end
                end

                c_st_nib: begin
                    if (r_cnt == c_e_on) begin
                        r_ctl_e <= 1'b1;
                    end
                    if (r_cnt == c_e_off) begin
                        r_ctl_e    <= 1'b0;
                        r_ctl_sf_d <= 4'h0;
                        r_state    <= c_st_nib_wait;
                        r_cnt      <= '0;
                    end
                end

                c_st_nib_wait: begin
                    if (r_cnt == w_nib_wait_lim) begin
                        r_cnt <= '0;
                        if (r_idx == 2'd3) begin
                            // Hand the pins to command_sender from the first config start on.
                            r_state    <= c_st_cfg_issue;
                            r_idx      <= 2'd0;
                            r_mux_cs   <= 1'b1;
                            r_cs_start <= 1'b1;
                            r_cs_rs    <= 1'b0;
                            r_cs_data  <= cfg_byte(2'd0);
                        end else begin
                            r_state    <= c_st_nib;
                            r_idx      <= r_idx + 2'd1;
                            r_ctl_sf_d <= init_nibble(r_idx + 2'd1);
                        end
                    end
                end

                c_st_cfg_issue: begin
                    r_state <= c_st_cfg_wait;
                    r_cnt   <= '0;
                end

                c_st_cfg_wait: begin
                    if (r_cnt == w_cfg_lim) begin
                        r_cnt <= '0;
                        if (r_idx == 2'd3) begin
                            r_state     <= c_st_idle;
                            r_init_done <= 1'b1;
                            r_req_ready <= 1'b1;
                        end else begin
                            r_state    <= c_st_cfg_issue;
                            r_idx      <= r_idx + 2'd1;
                            r_cs_start <= 1'b1;
                            r_cs_rs    <= 1'b0;
                            r_cs_data  <= cfg_byte(r_idx + 2'd1);
                        end
                    end
                end

                c_st_idle: begin
                    if (req_valid) begin
                        r_state     <= c_st_issue;
                        r_cnt       <= '0;
                        r_req_ready <= 1'b0;
                        r_cs_start  <= 1'b1;
                        r_cs_rs     <= req_rs;
                        r_cs_data   <= req_data;
                    end
                end

                c_st_issue: begin
                    r_state <= c_st_busy;
                    r_cnt   <= '0;
                end

                c_st_busy: begin
                    if (r_cnt == w_busy_lim) begin
                        r_state     <= c_st_idle;
                        r_cnt       <= '0;
                        r_req_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state <= c_st_pwr_wait;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign init_done = r_init_done;
    assign cs_start  = r_cs_start;
    assign cs_rs     = r_cs_rs;
    assign cs_rw     = 1'b0;
    assign cs_data   = r_cs_data;

    assign lcd_rs = r_mux_cs ? cs_lcd_rs : 1'b0;
    assign sf_d   = r_mux_cs ? cs_sf_d   : r_ctl_sf_d;
    assign lcd_rw = r_mux_cs ? cs_lcd_rw : 1'b0;
    assign lcd_e  = r_mux_cs ? cs_lcd_e  : r_ctl_e;

endmodule
`default_nettype wire

// File: tb/tb_lcd_init_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_lcd_init_controller
// Description : Directed self-checking bench for lcd_init_controller with a
//               small behavioural stand-in for command_sender.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_init_controller;

    localparam int T_POWERON = 100;
    localparam int T_INIT1   = 40;
    localparam int T_INIT2   = 20;
    localparam int T_INIT3   = 10;
    localparam int NIB_PULSE = 12;
    localparam int T_CMD     = 3110;
    localparam int T_CLEAR   = 4000;
    localparam int BOUND     = 20000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, init_done, cs_start, cs_rs, cs_rw;
    logic [7:0] cs_data;
    logic       cs_lcd_rs = 1'b0;
    logic [3:0] cs_sf_d = 4'h0;
    logic       cs_lcd_rw = 1'b0;
    logic       cs_lcd_e = 1'b0;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [3:0] sf_d;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         rise_q[$];
    logic [4:0] rise_pin_q[$];
    int         fall_q[$];
    int         start_q[$];
    logic [8:0] start_d_q[$];
    logic       r_prev_e = 1'b0;
    logic       r_trk = 1'b0;
    int         trk_err = 0;
    int         c0, rb, fb, sb, acc_neg;

    lcd_init_controller #(
        .T_POWERON (T_POWERON),
        .T_INIT1   (T_INIT1),
        .T_INIT2   (T_INIT2),
        .T_INIT3   (T_INIT3),
        .NIB_PULSE (NIB_PULSE),
        .T_CMD     (T_CMD),
        .T_CLEAR   (T_CLEAR)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .req_ready (req_ready),
        .init_done (init_done),
        .cs_start  (cs_start),
        .cs_rs     (cs_rs),
        .cs_rw     (cs_rw),
        .cs_data   (cs_data),
        .cs_lcd_rs (cs_lcd_rs),
        .cs_sf_d   (cs_sf_d),
        .cs_lcd_rw (cs_lcd_rw),
        .cs_lcd_e  (cs_lcd_e),
        .lcd_rs    (lcd_rs),
        .sf_d      (sf_d),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled just after each active edge; cyc is the edge index.
    always @(posedge clk) begin
        #1;
        if (lcd_e && !r_prev_e) begin
            rise_q.push_back(cyc);
            rise_pin_q.push_back({lcd_rs, sf_d});
        end
        if (!lcd_e && r_prev_e) fall_q.push_back(cyc);
        if (cs_start) begin
            start_q.push_back(cyc);
            start_d_q.push_back({cs_rs, cs_data});
        end
        if (!rst && (r_trk || cs_start) &&
            ({lcd_rs, lcd_rw, lcd_e, sf_d} != {cs_lcd_rs, cs_lcd_rw, cs_lcd_e, cs_sf_d}))
            trk_err <= trk_err + 1;
        r_prev_e <= lcd_e;
        if (rst) r_trk <= 1'b0;
        else if (cs_start) r_trk <= 1'b1;
    end

    // Stand-in for command_sender: high nibble, then low nibble sampled mid-sequence.
    initial begin
        forever begin
            @(negedge clk);
            if (cs_start === 1'b1) begin
                cs_lcd_rs = cs_rs;
                cs_sf_d   = cs_data[7:4];
                repeat (2) @(negedge clk);
                cs_lcd_e = 1'b1;
                repeat (12) @(negedge clk);
                cs_lcd_e = 1'b0;
                repeat (40) @(negedge clk);
                cs_sf_d = cs_data[3:0];
                repeat (2) @(negedge clk);
                cs_lcd_e = 1'b1;
                repeat (12) @(negedge clk);
                cs_lcd_e = 1'b0;
                repeat (2) @(negedge clk);
                cs_lcd_rs = 1'b0;
                cs_sf_d   = 4'h0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic apply_reset(input string tag, input int n);
        rst = 1'b1;
        @(negedge clk);
        check_eq({tag, "_pins"}, {25'd0, lcd_rs, lcd_rw, lcd_e, sf_d}, 32'd0);
        check_eq({tag, "_ready_done"}, {30'd0, req_ready, init_done}, 32'd0);
        check_eq({tag, "_cs_out"}, {22'd0, cs_start, cs_rs, cs_data}, 32'd0);
        repeat (n - 1) @(negedge clk);
        rst = 1'b0;
        c0  = cyc;
        rb  = rise_q.size();
        fb  = fall_q.size();
        sb  = start_q.size();
    endtask

    task automatic wait_starts(input string tag, input int n);
        int k = 0;
        while (start_q.size() < sb + n && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        if (start_q.size() < sb + n) begin
            check_eq({tag, "_start_timeout"}, start_q.size() - sb, n);
            finish_test();
        end
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!req_ready && k < BOUND) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            check_eq({tag, "_ready_timeout"}, {31'd0, req_ready}, 32'd1);
            finish_test();
        end
    endtask

    task automatic send_req(input logic rs, input logic [7:0] d);
        req_rs    = rs;
        req_data  = d;
        req_valid = 1'b1;
        wait_ready("send");
        acc_neg = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Nibble timing and config starts relative to the last reset release.
    task automatic check_init_seq(input string p);
        int         gap_exp[3] = '{42, 22, 12};
        logic [7:0] cfg_exp[4] = '{8'h28, 8'h06, 8'h0C, 8'h01};
        check_eq({p, "_first_rise"}, rise_q[rb] - c0, 102);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s_nib%0d", p, i), rise_pin_q[rb + i], (i == 3) ? 5'h02 : 5'h03);
            check_eq($sformatf("%s_e_width%0d", p, i), fall_q[fb + i] - rise_q[rb + i], 12);
        end
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("%s_gap%0d", p, i), rise_q[rb + i + 1] - fall_q[fb + i], gap_exp[i]);
        check_eq({p, "_cfg_after_nib"}, start_q[sb] - fall_q[fb + 3], 10);
        check_eq({p, "_cfg_first"}, start_q[sb] - c0, 236);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("%s_cfg_data%0d", p, i), start_d_q[sb + i], {1'b0, cfg_exp[i]});
            if (i > 0)
                check_eq($sformatf("%s_cfg_space%0d", p, i), start_q[sb + i] - start_q[sb + i - 1], 3110);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on init and configuration
        apply_reset("por", 3);
        wait_starts("init", 4);
        begin : b_wait_done
            int k = 0;
            while (!init_done && k < BOUND) begin
                @(negedge clk);
                k++;
            end
        end
        check_eq("init_done", {31'd0, init_done}, 32'd1);
        check_init_seq("a");
        check_eq("done_after_clear", cyc - start_q[sb + 3], 4000);
        check_eq("done_abs", cyc - c0, 13566);
        check_eq("ready_at_done", {31'd0, req_ready}, 32'd1);
        check_eq("cfg28_hi_nib", rise_pin_q[rb + 4], 5'h02);
        check_eq("cfg28_lo_nib", rise_pin_q[rb + 5], 5'h08);

        // Single character
        rb = rise_q.size();
        sb = start_q.size();
        send_req(1'b1, 8'h41);
        check_eq("char_latency", start_q[sb] - acc_neg, 1);
        check_eq("char_start_data", start_d_q[sb], 9'h141);
        check_eq("char_ready_low", {31'd0, req_ready}, 32'd0);
        repeat (100) @(negedge clk);
        check_eq("char_hold", {23'd0, cs_rs, cs_data}, 9'h141);
        wait_ready("char");
        check_eq("char_ready_period", cyc - acc_neg, T_CMD);
        check_eq("char_hi_nib", rise_pin_q[rb], 5'h14);
        check_eq("char_lo_nib", rise_pin_q[rb + 1], 5'h11);

        // Back-to-back with the request held high
        sb = start_q.size();
        send_req(1'b0, 8'h01);
        send_req(1'b1, 8'h48);
        send_req(1'b1, 8'h49);
        check_eq("b2b_clear_space", start_q[sb + 1] - start_q[sb], 4000);
        check_eq("b2b_char_space", start_q[sb + 2] - start_q[sb + 1], 3110);
        check_eq("b2b_data1", start_d_q[sb + 1], 9'h148);
        check_eq("b2b_data2", start_d_q[sb + 2], 9'h149);

        // Reset during BUSY, with a request already pending
        repeat (20) @(negedge clk);
        req_rs    = 1'b1;
        req_data  = 8'h48;
        req_valid = 1'b1;
        apply_reset("busy_rst", 3);
        wait_starts("replay1", 1);
        check_eq("replay1_cfg_first", start_q[sb] - c0, 236);
        check_eq("replay1_cfg_data", start_d_q[sb], 9'h028);
        check_eq("replay1_ready", {31'd0, req_ready}, 32'd0);

        // Reset during config wait while the sender is driving the pins
        repeat (4) @(negedge clk);
        apply_reset("cfg_rst", 3);
        wait_starts("replay2", 5);
        req_valid = 1'b0;
        check_init_seq("c");
        check_eq("held_req_space", start_q[sb + 4] - start_q[sb + 3], 4001);
        check_eq("held_req_data", start_d_q[sb + 4], 9'h148);
        check_eq("replay2_done", {31'd0, init_done}, 32'd1);
        check_eq("cs_rw", {31'd0, cs_rw}, 32'd0);
        repeat (5) @(negedge clk);
        check_eq("pin_track", trk_err, 0);
        finish_test();
    end

endmodule
`default_nettype wire
